async_hs_req_master: RTL and testbench

// - Multi-channel, single-clock initiator of a 4-phase req/ack handshake towards a foreign clock domain.
// - Up to CHN_N local requesters each queue one transfer; a round-robin arbiter serialises them onto one hs_req/hs_data/hs_chn bundle.
// - hs_ack returns asynchronously and is synchronised internally. Sits between APB-side control logic and an audio-clock consumer.

---
 rtl/async_hs_req_master.sv | 181 ++++++++++++++++++
 tb/tb_async_hs_req_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_hs_req_master.sv
// Multi-channel 4-phase req/ack initiator: round-robin arbitration of per-channel
// single-entry requests onto one handshake bundle. Optional timeout via ASYNC_HS_TIMEOUT_EN.
module async_hs_req_master #(
    parameter int CHN_N            = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int TIMEOUT_CYCLES   = 1023,
    parameter int simulation_delay = 1,
    localparam int CHN_W = (CHN_N > 1) ? $clog2(CHN_N) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHN_N-1:0]            chn_req,
    input  logic [CHN_N*DATA_WIDTH-1:0] chn_data,
    output logic [CHN_N-1:0]            chn_busy,
    output logic [CHN_N-1:0]            chn_done,
    output logic [CHN_N-1:0]            chn_err,
    output logic                        hs_req,
    output logic [DATA_WIDTH-1:0]       hs_data,
    output logic [CHN_W-1:0]            hs_chn,
    input  logic                        hs_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   ack_s;
    logic [1:0]             state_reg, state_next;
    logic [CHN_W-1:0]       rr_ptr_reg, grant_idx;
    logic [CHN_N-1:0]       pending_vec, busy_vec, done_reg;
    logic [DATA_WIDTH-1:0]  buf_data [CHN_N];
    logic                   hs_req_reg;
    logic [DATA_WIDTH-1:0]  hs_data_reg;
    logic [CHN_W-1:0]       hs_chn_reg;
    logic                   grant_fire, req_drop, rel_exit, set_err, tmo, rel_err;
    logic                   unused_cfg;

    always_ff @(posedge clk) begin
        if (rst) ack_sync_reg <= '0;
        else     ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], hs_ack};
    end
    assign ack_s = ack_sync_reg[SYNC_STAGES-1];

    // One-deep request slot per channel; busy covers pending plus the active handshake.
    generate
        for (genvar gi = 0; gi < CHN_N; gi++) begin : g_chn
            logic                  pend_reg, busy_reg, accept;
            logic [DATA_WIDTH-1:0] data_reg;

            assign accept = chn_req[gi] && !busy_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_reg <= 1'b0;
                    busy_reg <= 1'b0;
                end else if (accept) begin
                    pend_reg <= 1'b1;
                    busy_reg <= 1'b1;
                end else begin
                    if (grant_fire && grant_idx == CHN_W'(gi)) pend_reg <= 1'b0;
                    if (rel_exit && hs_chn_reg == CHN_W'(gi)) busy_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (accept) data_reg <= chn_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end

            assign pending_vec[gi] = pend_reg;
            assign busy_vec[gi]    = busy_reg;
            assign buf_data[gi]    = data_reg;
        end
    endgenerate

    // Scan downwards so the smallest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        for (int k = CHN_N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= CHN_N) idx = idx - CHN_N;
            if (pending_vec[CHN_W'(idx)]) grant_idx = CHN_W'(idx);
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        req_drop   = 1'b0;
        set_err    = 1'b0;
        rel_exit   = 1'b0;
        case (state_reg)
            ST_IDLE: if (|pending_vec) begin
                grant_fire = 1'b1;
                state_next = ST_REQ;
            end
            ST_REQ: if (ack_s) begin
                req_drop   = 1'b1;
                state_next = ST_REL;
            end else if (tmo) begin
                req_drop   = 1'b1;
                set_err    = 1'b1;
                state_next = ST_REL;
            end
            ST_REL: if (!ack_s || tmo) begin
                rel_exit   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= '0;
            hs_req_reg  <= 1'b0;
            hs_data_reg <= '0;
            hs_chn_reg  <= '0;
            done_reg    <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= '0;
            if (grant_fire) begin
                hs_req_reg  <= 1'b1;
                hs_data_reg <= buf_data[grant_idx];
                hs_chn_reg  <= grant_idx;
            end
            if (req_drop) hs_req_reg <= 1'b0;
            if (rel_exit) begin
                if (!rel_err) done_reg[hs_chn_reg] <= 1'b1;
                rr_ptr_reg <= (hs_chn_reg == CHN_W'(CHN_N - 1)) ? '0 : hs_chn_reg + CHN_W'(1);
            end
        end
    end

`ifdef ASYNC_HS_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

    logic [TMR_W-1:0] tmr_reg;
    logic             err_flag_reg;
    logic [CHN_N-1:0] err_reg;

    assign tmo     = (state_reg != ST_IDLE) && (tmr_reg == TMR_W'(TIMEOUT_CYCLES - 1));
    // A REL timeout is only an error if ack never dropped in that same cycle.
    assign rel_err = err_flag_reg || (tmo && ack_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_reg      <= '0;
            err_flag_reg <= 1'b0;
            err_reg      <= '0;
        end else begin
            err_reg <= '0;
            if (state_next != state_reg || state_reg == ST_IDLE) tmr_reg <= '0;
            else                                                 tmr_reg <= tmr_reg + TMR_W'(1);
            if (grant_fire)   err_flag_reg <= 1'b0;
            else if (set_err) err_flag_reg <= 1'b1;
            if (rel_exit && rel_err) err_reg[hs_chn_reg] <= 1'b1;
        end
    end

    assign chn_err    = err_reg;
    assign unused_cfg = (simulation_delay != 0);
`else
    assign tmo        = 1'b0;
    assign rel_err    = 1'b0;
    assign chn_err    = '0;
    assign unused_cfg = ^{set_err, (TIMEOUT_CYCLES != 0), (simulation_delay != 0)};
`endif

    assign chn_busy = busy_vec;
    assign chn_done = done_reg;
    assign hs_req   = hs_req_reg;
    assign hs_data  = hs_data_reg;
    assign hs_chn   = hs_chn_reg;

endmodule

// File: tb/tb_async_hs_req_master.sv
// Bench for async_hs_req_master: transaction-level channel model plus an echoing
// foreign-side responder; directed scenarios followed by a randomized phase.
module tb_async_hs_req_master;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    chn_req;
    logic [N*DW-1:0] chn_data;
    logic [N-1:0]    chn_busy, chn_done, chn_err;
    logic            hs_req;
    logic [DW-1:0]   hs_data;
    logic [1:0]      hs_chn;
    logic            hs_ack;

    always #5 clk = ~clk;

    async_hs_req_master #(
        .CHN_N(N), .DATA_WIDTH(DW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .simulation_delay(1)
    ) dut (
        .clk(clk), .rst(rst), .chn_req(chn_req), .chn_data(chn_data),
        .chn_busy(chn_busy), .chn_done(chn_done), .chn_err(chn_err),
        .hs_req(hs_req), .hs_data(hs_data), .hs_chn(hs_chn), .hs_ack(hs_ack)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel slot state, RR pointer, currently served channel.
    bit            mbusy [N];
    bit            mpend [N];
    logic [DW-1:0] mdata [N];
    int            mrr, mact;
    bit            mact_v, exp_err, prev_req;
    logic [DW-1:0] m_hs_data;
    int            m_hs_chn;
    int            served_q[$];
    int            dut_done_cnt [N];
    int            mode, dly;   // mode: 0 echo, 1 stuck low, 2 stuck high
    logic [7:0]    hist;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_busy_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (mpend[(mrr + k) % N]) return (mrr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mbusy[i] = 0;
            mpend[i] = 0;
        end
        mrr = 0; mact = 0; mact_v = 0; m_hs_data = '0; m_hs_chn = 0;
    endtask

    task automatic tick();
        bit            acc  [N];
        logic [DW-1:0] accd [N];
        bit            in_rst;
        logic [N-1:0]  vec;
        int            g;
        @(posedge clk);
        in_rst = rst;
        for (int i = 0; i < N; i++) begin
            acc[i]  = chn_req[i] && !mbusy[i];
            accd[i] = chn_data[i*DW +: DW];
        end
        #1;
        if (in_rst) begin
            model_reset();
        end else begin
            if (hs_req && !prev_req) begin
                g = pick();
                chk("grant_has_pending", 32'(g >= 0), 1);
                if (g >= 0) begin
                    mpend[g] = 0; mact = g; mact_v = 1;
                    m_hs_data = mdata[g]; m_hs_chn = g;
                end
            end
            if ((chn_done | chn_err) != 0) begin
                vec = mact_v ? (N'(1) << mact) : '0;
                chk("done_vec", chn_done, exp_err ? '0 : vec);
                chk("err_vec", chn_err, exp_err ? vec : '0);
                for (int i = 0; i < N; i++) dut_done_cnt[i] += int'(chn_done[i]);
                $display("xfer chn=%0d data=%02h done=%b err=%b t=%0t", mact, m_hs_data, chn_done, chn_err, $time);
                if (mact_v) begin
                    mbusy[mact] = 0;
                    mrr = (mact + 1) % N;
                    served_q.push_back(mact);
                    mact_v = 0;
                end
            end
            for (int i = 0; i < N; i++)
                if (acc[i]) begin
                    mbusy[i] = 1; mpend[i] = 1; mdata[i] = accd[i];
                end
        end
        chk("busy", chn_busy, model_busy_vec());
        chk("hs_data", hs_data, m_hs_data);
        chk("hs_chn", hs_chn, m_hs_chn);
        prev_req = hs_req;
        hist     = {hist[6:0], hs_req};
        hs_ack   = (mode == 0) ? hist[dly-1] : (mode == 2);
    endtask

    task automatic wait_req(input logic level, input int limit, output int n);
        n = 0;
        while (hs_req !== level && n < limit) begin tick(); n++; end
        chk("wait_hs_req", hs_req, level);
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        while ((chn_done | chn_err) == 0 && n < limit) begin tick(); n++; end
        chk("wait_pulse", 32'((chn_done | chn_err) != 0), 1);
    endtask

    task automatic wait_served(input int cnt, input int limit);
        int n = 0;
        while (served_q.size() < cnt && n < limit) begin tick(); n++; end
        chk("wait_served", served_q.size(), cnt);
    endtask

    task automatic do_reset();
        rst = 1; chn_req = '0; mode = 0; hist = '0; hs_ack = 0;
        tick(); tick();
        rst = 0;
        tick();
        served_q.delete();
        for (int i = 0; i < N; i++) dut_done_cnt[i] = 0;
    endtask

    int n;
    bit saw_a, saw_b;
    int exp_rr1 [4] = '{0, 1, 2, 3};
    int exp_rr2 [4] = '{1, 2, 3, 0};

    initial begin
        rst = 1; chn_req = '0; chn_data = '0; hs_ack = 0; mode = 0; dly = 3; hist = '0;
        exp_err = 0; prev_req = 0; model_reset();
        for (int i = 0; i < N; i++) dut_done_cnt[i] = 0;

        tick();
        chk("rst_hs_req", hs_req, 0);
        chk("rst_busy", chn_busy, 0);
        chk("rst_done", chn_done, 0);
        chk("rst_err", chn_err, 0);
        chk("rst_hs_data", hs_data, 0);
        chk("rst_hs_chn", hs_chn, 0);
        rst = 0;
        tick();

        // Single transfer on channel 2
        chn_req = 4'b0100; chn_data[23:16] = 8'hA5;
        tick();
        chn_req = '0;
        chk("single_req_c1", hs_req, 0);
        tick();
        chk("single_req_c2", hs_req, 1);
        chk("single_chn", hs_chn, 2);
        chk("single_data", hs_data, 8'hA5);
        wait_pulse(60, n);
        chk("single_done", chn_done, 4'b0100);
        chk("single_busy2", chn_busy[2], 0);
        tick();
        chk("single_done_1cyc", chn_done, 0);

        // Round-robin from rr_ptr=0, then from rr_ptr=1
        do_reset();
        chn_req = 4'b1111; chn_data = 32'h44332211;
        tick();
        chn_req = '0;
        wait_served(4, 200);
        for (int k = 0; k < 4; k++) chk("rr_order_a", served_q[k], exp_rr1[k]);
        served_q.delete();
        chn_req = 4'b0001; chn_data[7:0] = 8'h01;
        tick();
        chn_req = '0;
        wait_served(1, 60);
        served_q.delete();
        chn_req = 4'b1111; chn_data = 32'h88776655;
        tick();
        chn_req = '0;
        wait_served(4, 200);
        for (int k = 0; k < 4; k++) chk("rr_order_b", served_q[k], exp_rr2[k]);

        // Requests while busy are dropped; re-request in done cycle is taken
        do_reset();
        chn_req = 4'b0010; chn_data[15:8] = 8'h5A;
        tick();
        chn_req = '0;
        wait_req(1, 20, n);
        chn_req = 4'b0010; chn_data[15:8] = 8'hFF;
        tick();
        chn_req = '0;
        chk("ign_hs_data", hs_data, 8'h5A);
        wait_pulse(60, n);
        chk("ign_done", chn_done, 4'b0010);
        chn_req = 4'b0010; chn_data[15:8] = 8'h77;
        tick();
        chn_req = '0;
        chk("ign_reaccept", chn_busy[1], 1);
        wait_req(1, 30, n);
        chk("ign_new_data", hs_data, 8'h77);
        wait_pulse(60, n);
        repeat (30) tick();
        chk("ign_done_cnt", dut_done_cnt[1], 2);

        // Reset while in REQ with ch3 pending
        do_reset();
        chn_req = 4'b0001; chn_data[7:0] = 8'h3C;
        tick();
        chn_req = '0;
        wait_req(1, 20, n);
        chn_req = 4'b1000; chn_data[31:24] = 8'h99;
        tick();
        chn_req = '0;
        chk("rmo_busy3", chn_busy[3], 1);
        chk("rmo_in_req", hs_req, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rmo_hs_req", hs_req, 0);
        chk("rmo_busy", chn_busy, 0);
        chk("rmo_done", chn_done, 0);
        saw_a = 0;
        repeat (15) begin tick(); saw_a |= hs_req | (chn_done != 0); end
        chk("rmo_no_spurious", saw_a, 0);

`ifdef ASYNC_HS_TIMEOUT_EN
        // Ack stuck low: REQ times out, then REL exits with an error pulse
        do_reset();
        mode = 1; exp_err = 1;
        chn_req = 4'b0100; chn_data[23:16] = 8'h5C;
        tick();
        chn_req = '0;
        wait_req(1, 20, n);
        wait_req(0, 100, n);
        chk("tmo_req_len", n, TMO);
        wait_pulse(20, n);
        chk("tmo0_err", chn_err, 4'b0100);
        chk("tmo0_done", chn_done, 0);
        // Ack stuck high: REL times out
        mode = 2;
        repeat (4) tick();
        chn_req = 4'b1000; chn_data[31:24] = 8'hE1;
        tick();
        chn_req = '0;
        wait_req(1, 20, n);
        wait_req(0, 20, n);
        wait_pulse(100, n);
        chk("tmo_rel_len", n, TMO);
        chk("tmo1_err", chn_err, 4'b1000);
        chk("tmo1_done", chn_done, 0);
        exp_err = 0; mode = 0;
        repeat (6) tick();
`else
        // Ack stuck low: request is held indefinitely, no error ever
        do_reset();
        mode = 1;
        chn_req = 4'b0010; chn_data[15:8] = 8'h42;
        tick();
        chn_req = '0;
        wait_req(1, 20, n);
        saw_a = 0; saw_b = 0;
        repeat (5000) begin tick(); saw_a |= !hs_req; saw_b |= (chn_err != 0); end
        chk("stk_req_held", saw_a, 0);
        chk("stk_no_err", saw_b, 0);
        mode = 0;
        wait_pulse(60, n);
        chk("stk_done", chn_done, 4'b0010);
`endif

        // Randomized traffic
        do_reset();
        dly = $urandom_range(1, 4);
        repeat (400) begin
            for (int i = 0; i < N; i++) chn_req[i] = ($urandom_range(0, 3) == 0);
            chn_data = $urandom;
            tick();
        end
        chn_req = '0;
        n = 0;
        while (chn_busy !== '0 && n < 400) begin tick(); n++; end
        chk("rand_drain", chn_busy, 0);
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
